// File: rtl/cla_seq_adder_ctrl.sv
// Sequential wide adder that reuses one 4-bit carry-lookahead slice.
// Operands are processed one nibble per cycle, LSB first, with the slice carry-out registered between nibbles.
module cla_seq_adder_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             busy
);

  localparam int NCHUNK = WIDTH / 4;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int SEL_W  = (WIDTH > 4) ? $clog2(WIDTH) : 2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Returns {c3, c2, s[3:0]}; c2 is kept so the top slice can flag signed overflow.
  function automatic logic [5:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                      input logic ci);
    logic [3:0] p, g, c, s;
    p    = x ^ y;
    g    = x & y;
    c[0] = g[0] | (p[0] & ci);
    c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    s    = p ^ {c[2:0], ci};
    return {c[3], c[2], s};
  endfunction

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, wsum_q, wsum_d;
  logic             carry_q, carry_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d, ovf_q, ovf_d;

  logic [SEL_W-1:0] base;
  logic [5:0]       slice;
  logic             last;

  assign base  = SEL_W'({idx_q, 2'b00});
  assign slice = cla4(a_q[base +: 4], b_q[base +: 4], carry_q);
  assign last  = (idx_q == IDX_W'(NCHUNK - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    wsum_d  = wsum_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        wsum_d[base +: 4] = slice[3:0];
        carry_d           = slice[5];
        idx_d             = idx_q + IDX_W'(1);
        // Published outputs move only on the final nibble, so they hold across the next request.
        if (last) begin
          state_d = S_DONE;
          sum_d   = wsum_d;
          cout_d  = slice[5];
          ovf_d   = slice[5] ^ slice[4];
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      wsum_q  <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      wsum_q  <= wsum_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_cla_seq_adder_ctrl.sv
// Bench for cla_seq_adder_ctrl: 32-bit instance checked every cycle against an arithmetic model,
// plus a 4-bit instance for single-nibble latency.
module tb_cla_seq_adder_ctrl;
  localparam int W   = 32;
  localparam int NCH = W / 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          in_valid, in_ready, cin, out_valid, out_ready, cout, overflow, busy;
  logic [W-1:0]  a, b, sum;
  logic          in_valid4, in_ready4, cin4, out_valid4, out_ready4, cout4, overflow4, busy4;
  logic [3:0]    a4, b4, sum4;

  cla_seq_adder_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .overflow(overflow),
    .busy(busy));

  cla_seq_adder_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4), .a(a4), .b(b4),
    .cin(cin4), .out_valid(out_valid4), .out_ready(out_ready4), .sum(sum4), .cout(cout4),
    .overflow(overflow4), .busy(busy4));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: 0 = free, 1 = adding (counts edges since accept), 2 = result pending.
  int          m_st = 0;
  int          m_cnt = 0;
  bit          m_known = 1'b0;
  logic [31:0] m_sum = '0, p_sum = '0;
  logic        m_cout = 1'b0, m_ovf = 1'b0, p_cout = 1'b0, p_ovf = 1'b0;
  logic [32:0] tot;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_st = 0; m_cnt = 0; m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0; m_known = 1'b1;
    end else if (m_known) begin
      if (m_st == 0) begin
        if (in_valid) begin
          tot    = {1'b0, a} + {1'b0, b} + {32'd0, cin};
          p_sum  = tot[31:0];
          p_cout = tot[32];
          p_ovf  = (a[31] == b[31]) && (tot[31] != a[31]);
          m_cnt  = 0;
          m_st   = 1;
        end
      end else if (m_st == 1) begin
        m_cnt++;
        if (m_cnt == NCH) begin
          m_st = 2; m_sum = p_sum; m_cout = p_cout; m_ovf = p_ovf;
        end
      end else if (out_ready) begin
        m_st = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_known) begin
      chk("in_ready", 64'(in_ready), 64'(m_st == 0));
      chk("out_valid", 64'(out_valid), 64'(m_st == 2));
      chk("busy", 64'(busy), 64'(m_st != 0));
      chk("sum", 64'(sum), 64'(m_sum));
      chk("cout", 64'(cout), 64'(m_cout));
      chk("overflow", 64'(overflow), 64'(m_ovf));
    end
  end

  task automatic wait_idle();
    int g;
    g = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    while (!in_ready && g < 50) begin step(); g++; end
    chk("idle_wait", 64'(in_ready), 64'd1);
  endtask

  task automatic req32(input logic [31:0] ta, input logic [31:0] tb_, input logic tc,
                       input logic [31:0] es, input logic ec, input logic eo, input int stall);
    int lat;
    wait_idle();
    a = ta; b = tb_; cin = tc; in_valid = 1'b1; out_ready = (stall == 0);
    step();
    in_valid = 1'b0;
    lat = 0;
    do begin step(); lat++; end while (!out_valid && lat < 40);
    chk("latency32", 64'(lat), 64'(NCH));
    chk("sum_lit", 64'(sum), 64'(es));
    chk("cout_lit", 64'(cout), 64'(ec));
    chk("ovf_lit", 64'(overflow), 64'(eo));
    for (int i = 0; i < stall; i++) begin
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_sum", 64'(sum), 64'(es));
      chk("stall_cout", 64'(cout), 64'(ec));
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      in_valid = 1'b1; a = $urandom; b = $urandom; cin = 1'($urandom);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("idle_after_done", 64'(in_ready), 64'd1);
  endtask

  task automatic req4(input logic [3:0] ta, input logic [3:0] tb_, input logic tc,
                      input logic [3:0] es, input logic ec, input logic eo);
    int lat;
    a4 = ta; b4 = tb_; cin4 = tc; in_valid4 = 1'b1; out_ready4 = 1'b1;
    chk("w4_ready", 64'(in_ready4), 64'd1);
    step();
    in_valid4 = 1'b0;
    lat = 0;
    do begin step(); lat++; end while (!out_valid4 && lat < 10);
    chk("latency4", 64'(lat), 64'd1);
    chk("w4_sum", 64'(sum4), 64'(es));
    chk("w4_cout", 64'(cout4), 64'(ec));
    chk("w4_ovf", 64'(overflow4), 64'(eo));
    step();
    chk("w4_idle", 64'(in_ready4), 64'd1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired CHECKS %0d ERRORS %0d", n_chk, n_err);
    $fatal(1, "simulation time limit");
  end

  initial begin
    int acc, guard;
    logic rdy;
    rst_n = 1'b0;
    in_valid4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0; out_ready4 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'($urandom); a = $urandom; b = $urandom; cin = 1'($urandom);
      out_ready = 1'($urandom);
      step();
    end
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst4_sum", 64'(sum4), 64'd0);

    req32(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 0);
    req32(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 0);
    req32(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 0);
    req32(32'h1234_5678, 32'h1111_1111, 1'b1, 32'h2345_678A, 1'b0, 1'b0, 0);

    // Backpressure with ignored requests, then a fresh request must see only its own operands.
    req32(32'h0000_0005, 32'h0000_000A, 1'b1, 32'h0000_0010, 1'b0, 1'b0, 5);
    req32(32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0000_0003, 1'b0, 1'b0, 0);

    // Abort in the third RUN cycle.
    wait_idle();
    a = 32'hDEAD_BEEF; b = 32'h1234_5678; cin = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_sum", 64'(sum), 64'd0);
    chk("abort_cout", 64'(cout), 64'd0);
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 10; i++) begin
      chk("abort_quiet", 64'(out_valid), 64'd0);
      step();
    end
    req32(32'hFFFF_0000, 32'h0000_FFFF, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 0);

    // Random traffic with stalls; operands also toggle while busy.
    acc = 0; guard = 0;
    while (acc < 1000 && guard < 40000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      a = $urandom; b = $urandom; cin = 1'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      rdy = in_ready;
      step();
      if (in_valid && rdy) acc++;
      guard++;
    end
    chk("random_accepts", 64'(acc), 64'd1000);
    wait_idle();

    req4(4'hF, 4'h1, 1'b0, 4'h0, 1'b1, 1'b0);
    req4(4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 1'b1);
    req4(4'h8, 4'h8, 1'b0, 4'h0, 1'b1, 1'b1);
    req4(4'h5, 4'h2, 1'b1, 4'h8, 1'b0, 1'b1);

    step();
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
